// File: rtl/ps2_key_queue_pkg.sv
// Shared constants for the PS2 key queue: scan bytes, decoder states, event layout.
package ps2_key_queue_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_ERR0 = 8'h00;
    localparam logic [7:0] SC_ERR1 = 8'hFF;

    localparam int EV_W   = 10;
    localparam int EV_EXT = 9;
    localparam int EV_BRK = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO of key events; a pop on a full FIFO frees room for a same-cycle push.
module ps2_event_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int W      = 10
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              push,
    input  logic [W-1:0]      din,
    input  logic              pop,
    output logic [W-1:0]      dout,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [W-1:0]      mem_q [DEPTH];
    logic [W-1:0]      mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ps2_key_queue.sv
// PS2 set-2 scan byte decoder with typematic repeat filter, feeding a show-ahead event FIFO.
module ps2_key_queue
    import ps2_key_queue_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int ADDR_W        = 3,
    parameter int FILTER_REPEAT = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ps2_key_pressed,
    input  logic [7:0]        ps2_key_data,
    input  logic              rd_en,
    input  logic              ovf_clr,
    output logic              key_valid,
    output logic [EV_W-1:0]   key_event,
    output logic [ADDR_W:0]   key_count,
    output logic              overflow
);

    dec_state_t state_q, state_d;
    logic       dec_push, dec_ext, dec_brk;
    logic       repeat_hit, push;
    logic [8:0] last_make_q, last_make_d;
    logic       last_valid_q, last_valid_d;
    logic       overflow_q, overflow_d;
    logic       fifo_full, fifo_empty;
    logic [7:0] b;

    assign b = ps2_key_data;

    always_comb begin
        state_d  = state_q;
        dec_push = 1'b0;
        dec_ext  = 1'b0;
        dec_brk  = 1'b0;
        if (ps2_key_pressed) begin
            if (b == SC_ERR0 || b == SC_ERR1) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (b == SC_EXT)      state_d = ST_EXT;
                        else if (b == SC_BRK) state_d = ST_BRK;
                        else                  dec_push = 1'b1;
                    end
                    ST_EXT: begin
                        if (b == SC_BRK) state_d = ST_EXT_BRK;
                        else if (b != SC_EXT) begin
                            dec_push = 1'b1;
                            dec_ext  = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        // A new E0 abandons the pending break prefix
                        if (b == SC_EXT) state_d = ST_EXT;
                        else if (b != SC_BRK) begin
                            dec_push = 1'b1;
                            dec_brk  = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                    default: begin
                        if (b == SC_EXT) state_d = ST_EXT;
                        else if (b != SC_BRK) begin
                            dec_push = 1'b1;
                            dec_ext  = 1'b1;
                            dec_brk  = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Last-make tracking follows the filter decision, independent of FIFO room
    always_comb begin
        repeat_hit   = (FILTER_REPEAT != 0) && dec_push && !dec_brk && last_valid_q
                       && (last_make_q == {dec_ext, b});
        push         = dec_push && !repeat_hit;
        last_make_d  = last_make_q;
        last_valid_d = last_valid_q;
        if (push && !dec_brk) begin
            last_make_d  = {dec_ext, b};
            last_valid_d = 1'b1;
        end else if (push && dec_brk) begin
            last_valid_d = 1'b0;
        end
        if (push && fifo_full && !(rd_en && !fifo_empty)) overflow_d = 1'b1;
        else if (ovf_clr)                                  overflow_d = 1'b0;
        else                                               overflow_d = overflow_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            last_make_q  <= '0;
            last_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_make_q  <= last_make_d;
            last_valid_q <= last_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (EV_W)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .din    ({dec_ext, dec_brk, b}),
        .pop    (rd_en),
        .dout   (key_event),
        .count  (key_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign key_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: doc/ps2_key_queue.md
Name: ps2_key_queue

Overview:
Sits between the PS2 keyboard interface and the processor.
- Decodes raw PS2 set-2 scan bytes into key events: E0 extended prefix, F0 break prefix, make/break.
- Optionally suppresses typematic repeats.
- Buffers events in a show-ahead FIFO so the processor can poll and pop them at its own rate without losing keystrokes.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
ADDR_W, 3, log2(DEPTH).
FILTER_REPEAT, 1, 1 = drop a make code identical to the last accepted make with no intervening break.

Ports:
clock  input  1  system clock; all state on rising edge.
resetn  input  1  asynchronous, active-low reset.
ps2_key_pressed  input  1  one-cycle strobe; ps2_key_data valid this cycle.
ps2_key_data  input  8  raw scan byte.
rd_en  input  1  pop head entry; ignored when empty.
ovf_clr  input  1  clears overflow flag.
key_valid  output  1  FIFO non-empty.
key_event  output  10  head entry {extended, break, code[7:0]}; 10'h000 when empty.
key_count  output  ADDR_W+1  entries held, 0..DEPTH.
overflow  output  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
Interface
- Reset is asynchronous, active-low, on resetn; single clock domain, clock.
- Reset values: decoder in IDLE; FIFO empty; key_valid=0; key_event=0; key_count=0; overflow=0; last-make register cleared (valid=0).

Decoder FSM
- Advances only on cycles with ps2_key_pressed=1. Byte b = ps2_key_data.
- IDLE: b=E0 -> EXT; b=F0 -> BRK; else push {0,0,b}.
- EXT: b=F0 -> EXT_BRK; b=E0 -> stay; else push {1,0,b}, -> IDLE.
- BRK: b=F0 -> stay; b=E0 -> EXT (dangling break discarded); else push {0,1,b}, -> IDLE.
- EXT_BRK: b=F0 -> stay; b=E0 -> EXT; else push {1,1,b}, -> IDLE.
- b=00 or FF (PS2 error/overrun) in any state: nothing pushed, -> IDLE.

Repeat filter (FILTER_REPEAT=1)
- A make whose {extended, code} equals the last accepted make (last-make valid) is not pushed.
- An accepted make loads last-make and sets valid.
- Any break clears last-make valid.
- A filtered make is not an overflow and does not change FIFO state.

FIFO
- Push is registered: a byte strobed in cycle N appears at the head (key_valid=1) from cycle N+1 if the FIFO was empty.
- Show-ahead: key_event always reflects the head entry.
- Pop on rd_en with key_valid=1; head advances at the next edge.
- Pointers wrap modulo DEPTH. key_count tracks occupancy exactly.
- Push and pop in the same cycle, non-empty: both happen, count unchanged.
- Push and pop in the same cycle while full: both accepted, no overflow.
- Push while empty with rd_en=1: rd_en is ignored and the push is accepted.
- Push while full without pop: event dropped, overflow<=1, FIFO unchanged.
- ovf_clr coincident with a new drop: overflow stays 1 (set wins).
- Reset mid-sequence (for example after E0): FSM returns to IDLE, FIFO flushed, partial prefix lost.

Decomposition:
- Shared package: scan constants (SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ERR0=8'h00, SC_ERR1=8'hFF), decoder state encoding (IDLE, EXT, BRK, EXT_BRK), event field positions (EV_EXT=9, EV_BRK=8, EV_CODE=7:0).
- One sub-module, ps2_event_fifo: parameterised show-ahead FIFO with push/pop/count/full/empty. Decoder and filter stay in the top module.

Test Plan:
- Bytes 1C, F0,1C -> entries 10'h01C then 10'h11C; key_count=2; key_valid high one cycle after the first strobe.
- E0,75 then E0,F0,75 -> 10'h275 then 10'h375; the FSM returns to IDLE after each.
- FILTER_REPEAT=1: 1C,1C,1C,F0,1C,1C -> exactly 01C, 11C, 01C queued.
- Nine distinct makes with no pops (DEPTH=8) -> key_count=8, overflow=1, head still the first code. Pulse ovf_clr -> overflow=0. Full with push and rd_en in the same cycle -> count stays 8, overflow stays 0.
- E0 followed by FF, then 1C -> 10'h01C (error byte reset the prefix); rd_en while empty -> no change, key_count=0.
- Assert resetn=0 mid-run after E0 with 3 entries queued -> key_valid=0, key_count=0 immediately (async). Then 1C -> 10'h01C.
